// File: rtl/sfr_counter_arbiter_pkg.sv
// Shared definitions for the counter SFR arbiter.
package sfr_counter_arbiter_pkg;

  localparam int unsigned SIZE_DEFAULT = 5;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    ISSUE,
    CLEAR,
    SETTLE
  } state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin selection with a last-grant pointer.
module rr_arbiter2 (
  input  logic clk,
  input  logic rst,
  input  logic req0,
  input  logic req1,
  input  logic take,
  output logic any,
  output logic win
);

  logic last_q;
  logic last_d;

  // Winner: sole requester, or the one not granted most recently.
  always_comb begin
    any = req0 | req1;
    if (req0 && req1) begin
      win = ~last_q;
    end else begin
      win = req1;
    end
  end

  // Pointer follows every grant, refused or not.
  always_comb begin
    last_d = last_q;
    if (take && any) begin
      last_d = win;
    end
  end

  // Pointer register; 1 after reset so requester 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/sfr_counter_arbiter.sv
// Arbitrates two requesters onto an external up/down counter SFR,
// refusing any command that would make the counter wrap.
module sfr_counter_arbiter
  import sfr_counter_arbiter_pkg::*;
#(
  parameter int unsigned SIZE = SIZE_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0,
  input  logic            dir0,
  input  logic            req1,
  input  logic            dir1,
  input  logic            clr,
  input  logic [SIZE-1:0] cnt,
  output logic            incr,
  output logic            decr,
  output logic            ld,
  output logic            gnt0,
  output logic            gnt1,
  output logic            err0,
  output logic            err1,
  output logic            busy
);

  localparam logic [SIZE-1:0] MAX = '1;

  state_e state_q, state_d;

  logic incr_q, incr_d;
  logic decr_q, decr_d;
  logic ld_q,   ld_d;
  logic gnt0_q, gnt0_d;
  logic gnt1_q, gnt1_d;
  logic err0_q, err0_d;
  logic err1_q, err1_d;
  logic busy_q, busy_d;

  logic arb_any;
  logic arb_win;
  logic arb_take;
  logic win_dir;
  logic at_limit;

  rr_arbiter2 u_arb (
    .clk  (clk),
    .rst  (rst),
    .req0 (req0),
    .req1 (req1),
    .take (arb_take),
    .any  (arb_any),
    .win  (arb_win)
  );

  // Boundary check for the selected requester's direction.
  always_comb begin
    win_dir  = arb_win ? dir1 : dir0;
    at_limit = win_dir ? (cnt == MAX) : (cnt == '0);
  end

  // Next state and next outputs. Outputs are registered, so each one is
  // decided on the transition into the state in which it is visible;
  // INIT's load therefore shows up during the SETTLE that follows it.
  always_comb begin
    state_d  = state_q;
    incr_d   = 1'b0;
    decr_d   = 1'b0;
    ld_d     = 1'b0;
    gnt0_d   = 1'b0;
    gnt1_d   = 1'b0;
    err0_d   = 1'b0;
    err1_d   = 1'b0;
    arb_take = 1'b0;
    unique case (state_q)
      INIT: begin
        state_d = SETTLE;
        ld_d    = 1'b1;
      end
      IDLE: begin
        if (clr) begin
          state_d = CLEAR;
          ld_d    = 1'b1;
        end else if (arb_any) begin
          state_d  = ISSUE;
          arb_take = 1'b1;
          gnt0_d   = ~arb_win;
          gnt1_d   = arb_win;
          err0_d   = ~arb_win & at_limit;
          err1_d   = arb_win & at_limit;
          incr_d   = win_dir & ~at_limit;
          decr_d   = ~win_dir & ~at_limit;
        end
      end
      ISSUE:   state_d = SETTLE;
      CLEAR:   state_d = SETTLE;
      SETTLE:  state_d = IDLE;
      default: state_d = INIT;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset aborts any pending command.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
      incr_q  <= 1'b0;
      decr_q  <= 1'b0;
      ld_q    <= 1'b0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      err0_q  <= 1'b0;
      err1_q  <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      incr_q  <= incr_d;
      decr_q  <= decr_d;
      ld_q    <= ld_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      err0_q  <= err0_d;
      err1_q  <= err1_d;
      busy_q  <= busy_d;
    end
  end

  assign incr = incr_q;
  assign decr = decr_q;
  assign ld   = ld_q;
  assign gnt0 = gnt0_q;
  assign gnt1 = gnt1_q;
  assign err0 = err0_q;
  assign err1 = err1_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_sfr_counter_arbiter.sv
// Bench for sfr_counter_arbiter with a behavioural counter SFR and a
// transaction-level scoreboard.
module tb_sfr_counter_arbiter;

  localparam int unsigned SIZE = 5;
  localparam int MAXV = (1 << SIZE) - 1;

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic req0 = 1'b0;
  logic dir0 = 1'b0;
  logic req1 = 1'b0;
  logic dir1 = 1'b0;
  logic clr  = 1'b0;
  logic [SIZE-1:0] cnt = 5'd19;
  logic incr, decr, ld, gnt0, gnt1, err0, err1, busy;

  sfr_counter_arbiter #(.SIZE(SIZE)) dut (
    .clk  (clk),
    .rst  (rst),
    .req0 (req0),
    .dir0 (dir0),
    .req1 (req1),
    .dir1 (dir1),
    .clr  (clr),
    .cnt  (cnt),
    .incr (incr),
    .decr (decr),
    .ld   (ld),
    .gnt0 (gnt0),
    .gnt1 (gnt1),
    .err0 (err0),
    .err1 (err1),
    .busy (busy)
  );

  always #5 clk = ~clk;

  // Counter SFR: load-to-zero, increment, decrement.
  always @(posedge clk) begin
    if (ld) cnt <= '0;
    else if (incr) cnt <= cnt + 1'b1;
    else if (decr) cnt <= cnt - 1'b1;
  end

  typedef struct {
    bit is_ld;
    bit who;
    bit err;
    bit inc;
    bit dec;
    int cnt_after;
  } ev_t;

  ev_t    expq[$];
  int     n_pass = 0;
  int     n_checks = 0;
  int     model_cnt = 0;
  bit     model_last = 1'b1;
  longint cyc = 0;
  bit     gap_en = 1'b0;
  longint last_gnt_cyc = -1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic void model_load();
    ev_t e;
    e.is_ld = 1'b1; e.who = 1'b0; e.err = 1'b0; e.inc = 1'b0; e.dec = 1'b0;
    model_cnt = 0;
    e.cnt_after = 0;
    expq.push_back(e);
  endfunction

  function automatic void model_grant(input bit who, input bit dir);
    ev_t e;
    bit refused;
    refused = dir ? (model_cnt == MAXV) : (model_cnt == 0);
    if (!refused) model_cnt = dir ? model_cnt + 1 : model_cnt - 1;
    e.is_ld = 1'b0; e.who = who; e.err = refused;
    e.inc = dir && !refused; e.dec = !dir && !refused;
    e.cnt_after = model_cnt;
    model_last = who;
    expq.push_back(e);
  endfunction

  // Monitor: per-cycle exclusivity, event matching, counter follow-up.
  initial begin
    bit cnt_pend = 1'b0;
    int cnt_exp = 0;
    ev_t e;
    logic [6:0] actv, expv;
    forever begin
      @(negedge clk);
      cyc++;
      if (cnt_pend) begin
        check("cnt_after_cmd", 64'(cnt), 64'(cnt_exp));
        cnt_pend = 1'b0;
      end
      check("exclusive_outputs",
            64'(($onehot0({incr, decr, ld}) && !(gnt0 && gnt1)) ? 1 : 0), 64'd1);
      actv = {gnt0, gnt1, err0, err1, incr, decr, ld};
      if (gnt0 || gnt1 || ld) begin
        if (expq.size() == 0) begin
          check("unexpected_event", 64'(actv), 64'd0);
        end else begin
          e = expq.pop_front();
          expv = {!e.is_ld && !e.who, !e.is_ld && e.who, e.err && !e.who,
                  e.err && e.who, e.inc, e.dec, e.is_ld};
          check("event", 64'(actv), 64'(expv));
          cnt_pend = 1'b1;
          cnt_exp = e.cnt_after;
          if (!e.is_ld && gap_en) begin
            if (last_gnt_cyc >= 0) check("grant_gap", 64'(cyc - last_gnt_cyc), 64'd3);
            last_gnt_cyc = cyc;
          end
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("idle_timeout", 64'(busy), 64'd0);
  endtask

  task automatic go(input bit r0, input bit d0, input bit r1, input bit d1, input bit c);
    bit p0, p1, pc;
    int n = 0;
    p0 = r0; p1 = r1; pc = c;
    wait_idle();
    if (c) model_load();
    if (r0 && r1) begin
      if (model_last) begin model_grant(1'b0, d0); model_grant(1'b1, d1); end
      else begin model_grant(1'b1, d1); model_grant(1'b0, d0); end
    end else if (r0) model_grant(1'b0, d0);
    else if (r1) model_grant(1'b1, d1);
    req0 = r0; dir0 = d0; req1 = r1; dir1 = d1; clr = c;
    while ((p0 || p1 || pc) && n < 60) begin
      @(negedge clk);
      n++;
      if (gnt0) begin p0 = 1'b0; req0 = 1'b0; end
      if (gnt1) begin p1 = 1'b0; req1 = 1'b0; end
      if (ld)   begin pc = 1'b0; clr = 1'b0; end
    end
    if (p0 || p1 || pc) check("op_timeout", 64'({p0, p1, pc}), 64'd0);
    req0 = 1'b0; req1 = 1'b0; clr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    int n;
    int kind;
    bit dbias;
    model_last = 1'b1;
    model_load();

    // Reset and INIT
    repeat (2) @(negedge clk);
    check("reset_outputs", 64'({incr, decr, ld, gnt0, gnt1, err0, err1, busy}), 64'h01);
    rst = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (busy !== 1'b0 && n < 10);
    check("idle_latency", 64'(n), 64'd2);
    check("cnt_init", 64'(cnt), 64'd0);

    // Count up to MAX, then one refused increment
    for (int i = 0; i < MAXV; i++) go(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    wait_idle();
    check("cnt_full", 64'(cnt), 64'(MAXV));
    go(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    wait_idle();
    check("cnt_held_at_max", 64'(cnt), 64'(MAXV));

    // Clear with a request raised and withdrawn while busy
    wait_idle();
    model_load();
    clr = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!ld && n < 10);
    clr = 1'b0;
    req1 = 1'b1; dir1 = 1'b1;
    @(negedge clk);
    req1 = 1'b0;
    wait_idle();
    check("cnt_cleared", 64'(cnt), 64'd0);

    // Refused decrement at zero
    go(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    wait_idle();
    check("cnt_held_at_zero", 64'(cnt), 64'd0);

    // Both held: alternate 0,1,0,1 with 3-cycle spacing
    last_gnt_cyc = -1;
    gap_en = 1'b1;
    go(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    go(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    gap_en = 1'b0;
    wait_idle();
    check("cnt_after_alternation", 64'(cnt), 64'd4);

    // clr beats req0 at cnt=7
    for (int i = 0; i < 3; i++) go(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    wait_idle();
    check("cnt_seven", 64'(cnt), 64'd7);
    go(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    wait_idle();
    check("cnt_after_clr_then_grant", 64'(cnt), 64'd1);

    // Reset in the ISSUE cycle
    wait_idle();
    model_grant(1'b0, 1'b1);
    req0 = 1'b1; dir0 = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!gnt0 && n < 10);
    check("issue_seen", 64'(gnt0), 64'd1);
    rst = 1'b1; req0 = 1'b0;
    model_last = 1'b1;
    model_load();
    @(negedge clk);
    check("reset_in_issue", 64'({gnt0, gnt1, ld, incr, decr, busy}), 64'h01);
    rst = 1'b0;
    wait_idle();
    check("cnt_after_reset", 64'(cnt), 64'd0);

    // Randomised traffic, biased up then down to reach both limits
    for (int i = 0; i < 80; i++) begin
      dbias = (i < 40);
      kind = $urandom_range(0, 5);
      case (kind)
        0: go(1'b1, dbias ^ ($urandom_range(0, 4) == 0), 1'b0, 1'b0, 1'b0);
        1: go(1'b0, 1'b0, 1'b1, dbias ^ ($urandom_range(0, 4) == 0), 1'b0);
        2, 5: go(1'b1, dbias, 1'b1, dbias ^ ($urandom_range(0, 4) == 0), 1'b0);
        3: go(1'b0, 1'b0, 1'b0, 1'b0, ($urandom_range(0, 3) == 0));
        default: go(1'b0, 1'b0, 1'b1, $urandom_range(0, 1) == 1, 1'b1);
      endcase
    end

    wait_idle();
    repeat (3) @(negedge clk);
    check("scoreboard_drained", 64'(expq.size()), 64'd0);
    check("cnt_final", 64'(cnt), 64'(model_cnt));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
